// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings and FSM state type for the HI/LO multiply/divide unit
package muldiv_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
    localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
    localparam logic [OP_W-1:0] OP_MADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_MADDU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_seq_core.sv
// rtl/muldiv_seq_core.sv - unsigned one-bit-per-cycle shift-add multiplier / restoring divider
module muldiv_seq_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     ma_i,
    input  logic [WIDTH-1:0]     mb_i,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   prod_o,
    output logic [WIDTH-1:0]     quot_o,
    output logic [WIDTH-1:0]     rem_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   u_q, u_d;
    logic [WIDTH-1:0] l_q, l_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   shifted, diff, sum;

    // u holds the running partial product high half / partial remainder,
    // l holds the multiplier being consumed / dividend shifting into quotient bits.
    always_comb begin
        shifted = {u_q[WIDTH-1:0], l_q[WIDTH-1]};
        diff    = shifted - {1'b0, d_q};
        sum     = u_q + {1'b0, (l_q[0] ? d_q : {WIDTH{1'b0}})};
        last_o  = run_q && (cnt_q == CW'(WIDTH - 1));

        cnt_d = cnt_q;
        run_d = run_q;
        div_d = div_q;
        u_d   = u_q;
        l_d   = l_q;
        d_d   = d_q;

        if (load_i) begin
            cnt_d = '0;
            run_d = 1'b1;
            div_d = is_div_i;
            u_d   = '0;
            l_d   = is_div_i ? ma_i : mb_i;
            d_d   = is_div_i ? mb_i : ma_i;
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
            if (last_o) begin
                run_d = 1'b0;
            end
            if (div_q) begin
                if (!diff[WIDTH]) begin
                    u_d = diff;
                    l_d = {l_q[WIDTH-2:0], 1'b1};
                end else begin
                    u_d = shifted;
                    l_d = {l_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                u_d = {1'b0, sum[WIDTH:1]};
                l_d = {sum[0], l_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
            u_q   <= '0;
            l_q   <= '0;
            d_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
            div_q <= div_d;
            u_q   <= u_d;
            l_q   <= l_d;
            d_q   <= d_d;
        end
    end

    assign prod_o = {u_q[WIDTH-1:0], l_q};
    assign quot_o = l_q;
    assign rem_o  = u_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - multi-cycle mult/div unit owning HI/LO; MULDIV_MADD_EN adds MADD/MADDU
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wd,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d;
    logic             done_q, done_d, dz_q, dz_d;
    logic             sa_q, sa_d, sb_q, sb_d, div_q, div_d, bz_q, bz_d;
`ifdef MULDIV_MADD_EN
    logic             madd_q, madd_d;
`endif

    logic               op_legal, accept, op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
    logic [2*WIDTH-1:0] prod, prod_s, mult_res;
    logic               core_last;

    muldiv_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept),
        .is_div_i (op_div),
        .ma_i     (a_mag),
        .mb_i     (b_mag),
        .last_o   (core_last),
        .prod_o   (prod),
        .quot_o   (quot),
        .rem_o    (rem)
    );

    always_comb begin
`ifdef MULDIV_MADD_EN
        op_legal = (op <= OP_MADDU);
`else
        op_legal = (op <= OP_DIVU);
`endif
        accept    = start && (state_q == IDLE) && op_legal;
        op_signed = ~op[0];
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        prod_s = (sa_q ^ sb_q) ? -prod : prod;
`ifdef MULDIV_MADD_EN
        // Accumulator is HI/LO as they stand at FIX, so an E0 direct write is included.
        mult_res = madd_q ? (prod_s + {hi_q, lo_q}) : prod_s;
`else
        mult_res = prod_s;
`endif
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        bz_d    = bz_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
`ifdef MULDIV_MADD_EN
        madd_d  = madd_q;
`endif
        case (state_q)
            IDLE: begin
                if (hilo_we) begin
                    if (hilo_sel) hi_d = hilo_wd;
                    else          lo_d = hilo_wd;
                end
                if (accept) begin
                    state_d = RUN;
                    a_d     = a;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    div_d   = op_div;
                    bz_d    = (b == '0);
`ifdef MULDIV_MADD_EN
                    madd_d  = op[2];
`endif
                end
            end
            RUN: begin
                if (core_last) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    if (bz_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                        dz_d = 1'b1;
                    end else begin
                        // Quotient truncates toward zero; remainder follows the dividend sign.
                        lo_d = (sa_q ^ sb_q) ? -quot : quot;
                        hi_d = sa_q ? -rem : rem;
                    end
                end else begin
                    {hi_d, lo_d} = mult_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            bz_q    <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
            madd_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            bz_q    <= bz_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
`ifdef MULDIV_MADD_EN
            madd_q  <= madd_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
